// File: rtl/fifo_param.sv
// fifo_param: single-clock synchronous FIFO with registered read data.
//
// Parameters:
//   DATA_WIDTH - flit width in bits (>= 1)
//   DEPTH      - entry count, power of 2, >= 2
//   AFULL_LVL  - almost_full threshold, 1..DEPTH
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   write       - push request, data_in is stored when accepted
//   data_in     - push data
//   read        - pop request, accepted only when not empty
//   data_out    - registered pop data, held when no pop is accepted
//   data_valid  - high for the one cycle after an accepted pop
//   full        - count == DEPTH
//   empty       - count == 0
//   almost_full - count >= AFULL_LVL
//   count       - current occupancy
//   overflow    - sticky, set by a rejected push   (only with FIFO_ERR_EN)
//   underflow   - sticky, set by a rejected pop    (only with FIFO_ERR_EN)
//
// Build option: define FIFO_ERR_EN to add the overflow/underflow error flags.

module fifo_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AFULL_LVL  = DEPTH - 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        write,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        read,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        data_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic [$clog2(DEPTH):0]      count
`ifdef FIFO_ERR_EN
  ,
  output logic                        overflow,
  output logic                        underflow
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;

  logic                  push_ok;
  logic                  pop_ok;

  // Status flags come straight from the registered count.
  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == CW'(DEPTH));
    almost_full = (count_q >= CW'(AFULL_LVL));
  end

  // A pop is only possible with data present, so an empty FIFO never falls
  // through; a full FIFO can still take a push when a pop frees a slot.
  always_comb begin
    pop_ok  = read & ~empty;
    push_ok = write & (~full | pop_ok);
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d     = rd_ptr_q + AW'(1);
      data_out_d   = mem[rd_ptr_q];
      data_valid_d = 1'b1;
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage is not reset; rst_n gating drops a push that lands on an edge
  // while reset is held.
  always_ff @(posedge clk) begin
    if (push_ok && rst_n) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign count      = count_q;

`ifdef FIFO_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (write & ~push_ok);
      underflow_q <= underflow_q | (read & ~pop_ok);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed self-checking bench for fifo_param
// (DATA_WIDTH=8, DEPTH=8, AFULL_LVL=6). Error-flag checks are compiled in
// only when FIFO_ERR_EN is defined.

module tb_fifo_param;

  logic       clk;
  logic       rst_n;
  logic       write;
  logic [7:0] data_in;
  logic       read;
  logic [7:0] data_out;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [3:0] count;
`ifdef FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fifo_param #(
    .DATA_WIDTH(8),
    .DEPTH     (8),
    .AFULL_LVL (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write      (write),
    .data_in    (data_in),
    .read       (read),
    .data_out   (data_out),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .count      (count)
`ifdef FIFO_ERR_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    write   = w;
    read    = r;
    data_in = d;
    @(posedge clk);
    #1;
    write   = 1'b0;
    read    = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b want 0", almost_full); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h want 00", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_dvalid got %b want 0", data_valid); end
`ifdef FIFO_ERR_EN
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL reset_err got %b%b want 00", overflow, underflow); end
`endif
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0, 8'(i * 'h11));
      n_cmp++; if (count !== 4'(i)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
      n_cmp++; if (almost_full !== (i >= 6)) begin n_err++; $display("FAIL fill_afull[%0d] got %b want %b", i, almost_full, (i >= 6)); end
      n_cmp++; if (full !== (i == 8)) begin n_err++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 8)); end
      n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL fill_empty[%0d] got %b want 0", i, empty); end
      n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL fill_dvalid[%0d] got %b want 0", i, data_valid); end
    end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b0, 8'h99);
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_count got %0d want 8", count); end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b want 1", full); end
`ifdef FIFO_ERR_EN
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
    cycle(1'b0, 1'b0, 8'h00);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
`endif
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      n_cmp++; if (data_out !== 8'(i * 'h11)) begin n_err++; $display("FAIL drain_dout[%0d] got %h want %h", i, data_out, 8'(i * 'h11)); end
      n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL drain_dvalid[%0d] got %b want 1", i, data_valid); end
      n_cmp++; if (count !== 4'(8 - i)) begin n_err++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 8 - i); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", empty); end
    cycle(1'b0, 1'b0, 8'h00);
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL idle_dvalid got %b want 0", data_valid); end
    n_cmp++; if (data_out !== 8'h88) begin n_err++; $display("FAIL idle_hold got %h want 88", data_out); end
    // Pop on empty is ignored.
    cycle(1'b0, 1'b1, 8'h00);
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL udf_count got %0d want 0", count); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL udf_dvalid got %b want 0", data_valid); end
    n_cmp++; if (data_out !== 8'h88) begin n_err++; $display("FAIL udf_dout got %h want 88", data_out); end
`ifdef FIFO_ERR_EN
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_flag got %b want 1", underflow); end
`endif
  endtask

  task automatic test_simul_empty();
    cycle(1'b1, 1'b1, 8'hA5);
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL se_count got %0d want 1", count); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL se_dvalid got %b want 0", data_valid); end
    n_cmp++; if (data_out !== 8'h88) begin n_err++; $display("FAIL se_dout got %h want 88", data_out); end
    cycle(1'b0, 1'b1, 8'h00);
    n_cmp++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL se_pop got %h want a5", data_out); end
    n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL se_pop_dvalid got %b want 1", data_valid); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL se_empty got %b want 1", empty); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i));
    cycle(1'b1, 1'b1, 8'hEE);
    n_cmp++; if (data_out !== 8'h30) begin n_err++; $display("FAIL frw_dout got %h want 30", data_out); end
    n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL frw_dvalid got %b want 1", data_valid); end
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL frw_count got %0d want 8", count); end
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      n_cmp++;
      if (data_out !== ((i == 8) ? 8'hEE : 8'(8'h30 + i))) begin
        n_err++;
        $display("FAIL frw_drain[%0d] got %h want %h", i, data_out, ((i == 8) ? 8'hEE : 8'(8'h30 + i)));
      end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL frw_empty got %b want 1", empty); end
  endtask

  // Alternating push/pop bursts against a queue model; 40 accepted pushes
  // wrap the 3-bit pointers five times.
  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] exp_d;
    int         seq = 1;
    int         len;
    for (int b = 0; b < 20; b++) begin
      if (b % 2 == 0) begin
        len = 3 + 2 * ((b / 2) % 2);
        for (int k = 0; k < len; k++) begin
          cycle(1'b1, 1'b0, 8'(seq));
          if (q.size() < 8) q.push_back(8'(seq));
          seq++;
          n_cmp++; if (count !== 4'(q.size())) begin n_err++; $display("FAIL wrap_push_count b%0d got %0d want %0d", b, count, q.size()); end
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          cycle(1'b0, 1'b1, 8'h00);
          if (q.size() > 0) begin
            exp_d = q.pop_front();
            n_cmp++; if (data_out !== exp_d || data_valid !== 1'b1) begin n_err++; $display("FAIL wrap_pop b%0d got %h/%b want %h/1", b, data_out, data_valid, exp_d); end
          end else begin
            n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL wrap_udf b%0d got dvalid %b want 0", b, data_valid); end
          end
          n_cmp++; if (count !== 4'(q.size()) || count > 4'd8) begin n_err++; $display("FAIL wrap_pop_count b%0d got %0d want %0d", b, count, q.size()); end
        end
      end
    end
    // Leave the FIFO empty.
    while (q.size() > 0) begin
      cycle(1'b0, 1'b1, 8'h00);
      exp_d = q.pop_front();
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL wrap_tail got %h want %h", data_out, exp_d); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i));
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 8'h45);
    n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL ar_pre_count got %0d want 5", count); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL ar_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin n_err++; $display("FAIL ar_flags got e%b f%b a%b want e1 f0 a0", empty, full, almost_full); end
    n_cmp++; if (data_out !== 8'h00 || data_valid !== 1'b0) begin n_err++; $display("FAIL ar_dout got %h/%b want 00/0", data_out, data_valid); end
`ifdef FIFO_ERR_EN
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL ar_err got %b%b want 00", overflow, underflow); end
`endif
    // Push held across an edge while in reset is discarded.
    write   = 1'b1;
    data_in = 8'h77;
    @(posedge clk);
    #1;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL ar_discard got %0d want 0", count); end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL ar_first_push got %0d want 1", count); end
    cycle(1'b0, 1'b1, 8'h00);
    n_cmp++; if (data_out !== 8'h77) begin n_err++; $display("FAIL ar_first_pop got %h want 77", data_out); end
  endtask

  initial begin
    rst_n   = 1'b0;
    write   = 1'b0;
    read    = 1'b0;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_fill();
    test_overflow();
    test_drain();
    test_simul_empty();
    test_full_rw();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
